// File: rtl/tpu_pkg.sv
// Shared vector-unit types: Q8.8 fixed-point format, the leaky-ReLU derivative
// cache state encoding, and the codebase Q8.8 multiplier.
package tpu_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef logic signed [15:0] fxp_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } lrd_state_t;

  // Q8.8 x Q8.8 -> Q8.8: round half up on the dropped fraction, saturate to fxp_t range.
  function automatic fxp_t fxp_mul(input fxp_t a, input fxp_t b);
    logic signed [31:0] prod;
    logic signed [31:0] rnd;
    prod = 32'(a) * 32'(b);
    rnd  = (prod + 32'sd128) >>> FRAC_W;
    if (rnd > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (rnd < -32'sd32768) begin
      return 16'sh8000;
    end
    return rnd[15:0];
  endfunction

endpackage

// File: rtl/lrd_cache_mem.sv
// Activation cache storage for leaky_relu_deriv_stage: one synchronous write
// port, one combinational read port.
module lrd_cache_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the data array has no reset; occupancy and pointers alone decide which
  // entries are meaningful, so clearing the storage would only cost logic.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/leaky_relu_deriv_stage.sv
// Caches forward activations H in order and applies the leaky-ReLU derivative to
// backward gradients. Define LRD_EMPTY_BYPASS_EN to forward a same-cycle push to a pop while empty.
module leaky_relu_deriv_stage #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = tpu_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   fwd_valid_in,
  input  logic [DATA_W-1:0]      fwd_data_in,
  input  logic                   bwd_valid_in,
  input  logic [DATA_W-1:0]      bwd_grad_in,
  input  logic [DATA_W-1:0]      leak_factor,
  output logic [DATA_W-1:0]      bwd_data_out,
  output logic                   bwd_valid_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  import tpu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lrd_state_t        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              push_ok, pop_ok, bypass;
  logic              store, take;
  logic [DATA_W-1:0] mem_rdata, h_val;
  logic              h_pos;

  lrd_cache_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i (fwd_data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    bypass  = 1'b0;
    h_val   = mem_rdata;
    unique case (state_q)
      EMPTY: begin
        push_ok = fwd_valid_in;
`ifdef LRD_EMPTY_BYPASS_EN
        if (fwd_valid_in && bwd_valid_in) begin
          pop_ok = 1'b1;
          bypass = 1'b1;
          h_val  = fwd_data_in;
        end
`endif
      end
      PARTIAL: begin
        push_ok = fwd_valid_in;
        pop_ok  = bwd_valid_in;
      end
      FULL: begin
        push_ok = fwd_valid_in && bwd_valid_in;
        pop_ok  = bwd_valid_in;
      end
      default: ;
    endcase
    store = push_ok && !bypass && !clear;
    take  = pop_ok && !bypass;
    h_pos = !h_val[DATA_W-1] && (h_val != '0);
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    if (clear) begin
      state_d     = EMPTY;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (take)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(store) - CNT_W'(take);
      if (count_d == '0) begin
        state_d = EMPTY;
      end else if (count_d == CNT_W'(DEPTH)) begin
        state_d = FULL;
      end else begin
        state_d = PARTIAL;
      end
      overflow_d  = overflow_q || (fwd_valid_in && state_q == FULL && !bwd_valid_in);
      underflow_d = underflow_q || (bwd_valid_in && !pop_ok);
      out_valid_d = pop_ok;
      if (pop_ok) begin
        out_data_d = h_pos ? bwd_grad_in
                           : DATA_W'(fxp_mul(fxp_t'(bwd_grad_in), fxp_t'(leak_factor)));
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bwd_data_out  = out_data_q;
  assign bwd_valid_out = out_valid_q;
  assign count         = count_q;
  assign full          = (state_q == FULL);
  assign empty         = (state_q == EMPTY);
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_leaky_relu_deriv_stage.sv
// Directed, table-driven bench for leaky_relu_deriv_stage (DEPTH=16, Q8.8).
module tb_leaky_relu_deriv_stage;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        fv, bv;
  logic [15:0] fd, grad, leak;
  logic [15:0] dout;
  logic        vout;
  logic [4:0]  cnt;
  logic        full, empty, ovf, udf;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        fv;
    logic [15:0] fd;
    logic        bv;
    logic [15:0] grad;
    logic        ev;
    logic [15:0] ed;
    logic [4:0]  ecnt;
    logic        eempty;
  } vec_t;

  vec_t tbl [7];

  leaky_relu_deriv_stage #(.DEPTH(DEPTH), .DATA_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .fwd_valid_in  (fv),
    .fwd_data_in   (fd),
    .bwd_valid_in  (bv),
    .bwd_grad_in   (grad),
    .leak_factor   (leak),
    .bwd_data_out  (dout),
    .bwd_valid_out (vout),
    .count         (cnt),
    .full          (full),
    .empty         (empty),
    .overflow      (ovf),
    .underflow     (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic f, input logic [15:0] d, input logic b, input logic [15:0] g);
    fv = f; fd = d; bv = b; grad = g;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [15:0] d);
    check({tag, "_valid"}, 32'(vout), 32'(v));
    check({tag, "_data"}, 32'(dout), 32'(d));
  endtask

  // Fill pattern: even index negative, odd index positive.
  function automatic logic [15:0] hval(input int i);
    if (i % 2 == 0) return 16'hF000 + 16'(i);
    return 16'(16 * (i + 1));
  endfunction

  // grad 0x0200 (2.0), leak 0x0040 (0.25): positive H -> 0x0200, else 0x0080.
  function automatic logic [15:0] deriv_fill(input int i);
    return (i % 2 == 0) ? 16'h0080 : 16'h0200;
  endfunction

  task automatic fill_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, hval(i), 1'b0, 16'h0000);
      cyc();
    end
    drive(1'b0, 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 16'h0000);
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; leak = 16'h0040;
    drive(1'b0, 16'h0000, 1'b0, 16'h0000);
    #12;
    expect_out("reset", 1'b0, 16'h0000);
    check("reset_count", 32'(cnt), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_udf", 32'(udf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic push/pop with positive, negative and zero H.
    tbl[0] = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd1, 1'b0};
    tbl[1] = '{1'b1, 16'hFF00, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd2, 1'b0};
    tbl[2] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd3, 1'b0};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 16'h0200, 1'b1, 16'h0200, 5'd2, 1'b0};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 16'h0200, 1'b1, 16'h0080, 5'd1, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 16'h0200, 1'b1, 16'h0080, 5'd0, 1'b1};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b1};
    for (int r = 0; r < 7; r++) begin
      drive(tbl[r].fv, tbl[r].fd, tbl[r].bv, tbl[r].grad);
      cyc();
      expect_out($sformatf("tbl%0d", r), tbl[r].ev, tbl[r].ed);
      check($sformatf("tbl%0d_count", r), 32'(cnt), 32'(tbl[r].ecnt));
      check($sformatf("tbl%0d_empty", r), 32'(empty), 32'(tbl[r].eempty));
      check($sformatf("tbl%0d_full", r), 32'(full), 32'd0);
      check($sformatf("tbl%0d_flags", r), {30'd0, ovf, udf}, 32'd0);
    end

    // Fill, overflow, drain in order.
    fill_full();
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf_clean", 32'(ovf), 32'd0);
    drive(1'b1, 16'h1234, 1'b0, 16'h0000);
    cyc();
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_count", 32'(cnt), 32'(DEPTH));
    check("ovf_full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 16'h0000, 1'b1, 16'h0200);
      cyc();
      expect_out($sformatf("drain%0d", i), 1'b1, deriv_fill(i));
    end
    drive(1'b0, 16'h0000, 1'b0, 16'h0000);
    cyc();
    expect_out("drain_idle", 1'b0, 16'h0000);
    check("drain_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Underflow and clear.
    drive(1'b0, 16'h0000, 1'b1, 16'h0300);
    cyc();
    check("udf_set", 32'(udf), 32'd1);
    expect_out("udf_out", 1'b0, 16'h0000);
    do_clear();
    check("clr_udf", 32'(udf), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_count", 32'(cnt), 32'd0);

    // Simultaneous push+pop while FULL.
    fill_full();
    drive(1'b1, 16'h0500, 1'b1, 16'h0200);
    cyc();
    check("fullpp_count", 32'(cnt), 32'(DEPTH));
    check("fullpp_full", 32'(full), 32'd1);
    check("fullpp_ovf", 32'(ovf), 32'd0);
    expect_out("fullpp_out", 1'b1, deriv_fill(0));
    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b0, 16'h0000, 1'b1, 16'h0200);
      cyc();
      expect_out($sformatf("fullpp_pop%0d", i), 1'b1, deriv_fill(i));
    end
    drive(1'b0, 16'h0000, 1'b1, 16'hFE00);
    cyc();
    expect_out("fullpp_last", 1'b1, 16'hFE00);
    check("fullpp_empty", 32'(empty), 32'd1);

    // Wrap-around with grad -2.0: positive H -> 0xFE00, non-positive -> 0xFF80.
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < DEPTH / 2; j++) begin
        if (j % 2 == 0) drive(1'b1, 16'h0100 + 16'(r * 16 + j), 1'b0, 16'h0000);
        else if (j == 7) drive(1'b1, 16'h0000, 1'b0, 16'h0000);
        else drive(1'b1, 16'hFF00 - 16'(j), 1'b0, 16'h0000);
        cyc();
      end
      for (int j = 0; j < DEPTH / 2; j++) begin
        drive(1'b0, 16'h0000, 1'b1, 16'hFE00);
        cyc();
        expect_out($sformatf("wrap%0d_%0d", r, j), 1'b1, (j % 2 == 0) ? 16'hFE00 : 16'hFF80);
      end
    end
    drive(1'b0, 16'h0000, 1'b0, 16'h0000);
    cyc();
    check("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous push+pop while EMPTY.
    drive(1'b1, 16'hFF00, 1'b1, 16'h0200);
    cyc();
`ifdef LRD_EMPTY_BYPASS_EN
    check("epp_count", 32'(cnt), 32'd0);
    check("epp_udf", 32'(udf), 32'd0);
    expect_out("epp_out", 1'b1, 16'h0080);
`else
    check("epp_count", 32'(cnt), 32'd1);
    check("epp_udf", 32'(udf), 32'd1);
    expect_out("epp_out", 1'b0, 16'h0000);
    drive(1'b0, 16'h0000, 1'b1, 16'h0200);
    cyc();
    expect_out("epp_pop", 1'b1, 16'h0080);
    check("epp_empty", 32'(empty), 32'd1);
`endif
    do_clear();

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, hval(i + 1), 1'b0, 16'h0000);
      cyc();
    end
    check("mid_count5", 32'(cnt), 32'd5);
    drive(1'b0, 16'h0000, 1'b1, 16'h0200);
    cyc();
    expect_out("mid_pop", 1'b1, 16'h0200);
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 1'b0, 16'h0000);
    check("async_rst_count", 32'(cnt), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b1, 16'h0200);
    cyc();
    check("post_rst_udf", 32'(udf), 32'd1);
    expect_out("post_rst_out", 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
